// File: rtl/mem_bus_pkg.sv
// Shared definitions for bus initiators on the native picorv32 memory
// interface: FSM state type, strobe constants and address/mask helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  localparam logic [3:0] WSTRB_NONE = 4'h0;
  localparam logic [3:0] WSTRB_ALL  = 4'hF;

  // Byte address of word number idx counted from base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

  // Expand byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words.
// word/strb show the word including the byte being accepted this cycle;
// word_done flags that this byte completes the word (4th lane or last byte).
module byte_packer
  import mem_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [31:0] word,
  output logic [3:0]  strb,
  output logic        word_done
);

  logic [1:0]  byte_idx;
  logic [31:0] data_q;
  logic [3:0]  strb_q;

  // Merge the incoming byte into the lane selected by byte_idx.
  always_comb begin
    word = data_q;
    word[{byte_idx, 3'b000} +: 8] = data;
    strb = strb_q;
    strb[byte_idx] = 1'b1;
    word_done = accept && (last || (strb == WSTRB_ALL));
  end

  // Hold the partial word; a completed word is handed off and the lanes cleared
  // so unused lanes of a short final word read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      data_q   <= 32'd0;
      strb_q   <= WSTRB_NONE;
    end else if (accept) begin
      if (word_done) begin
        byte_idx <= 2'd0;
        data_q   <= 32'd0;
        strb_q   <= WSTRB_NONE;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        data_q   <= word;
        strb_q   <= strb;
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Program-memory loader: packs a byte stream into words, writes them to
// consecutive addresses (optionally reading each back), and releases the
// core from reset only after a clean load.
// Handshakes: a byte moves when s_valid & s_ready are both high at a clock
// edge; a bus transfer completes on the edge where mem_valid & mem_ready are
// both high, and mem_addr/mem_wdata/mem_wstrb hold while mem_valid is high.
module mem_loader
  import mem_bus_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter bit          VERIFY    = 1'b1,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count,
  output logic        core_resetn,
  output logic [1:0]  fsm_state
);

  localparam int          TW          = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MEM_WORDS_L = 17'(MEM_WORDS);

  state_t        st;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    strb_q;
  logic          last_q;

  logic [31:0] pk_word;
  logic [3:0]  pk_strb;
  logic        word_done;
  logic        tmo_hit;
  logic        overflow;
  logic        mismatch;
  logic [15:0] wc_next;

  assign mem_instr = 1'b0;
  assign fsm_state = st;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (s_valid & s_ready),
    .data      (s_data),
    .last      (s_last),
    .word      (pk_word),
    .strb      (pk_strb),
    .word_done (word_done)
  );

  // Per-cycle decisions: timeout reached, no room left, read-back mismatch.
  always_comb begin
    tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
    overflow = ({1'b0, word_count} >= MEM_WORDS_L);
    mismatch = (((mem_rdata ^ mem_wdata) & strb_mask(strb_q)) != 32'd0);
    wc_next  = (word_count == 16'hFFFF) ? word_count : word_count + 16'd1;
  end

  // Bus FSM with registered outputs and the request timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= ST_COLLECT;
      s_ready     <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= ADDR_BASE;
      mem_wdata   <= 32'd0;
      mem_wstrb   <= WSTRB_NONE;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= 16'd0;
      core_resetn <= 1'b0;
      tmo_cnt     <= '0;
      strb_q      <= WSTRB_NONE;
      last_q      <= 1'b0;
    end else begin
      case (st)
        ST_COLLECT: begin
          s_ready <= 1'b1;
          if (word_done) begin
            s_ready <= 1'b0;
            last_q  <= s_last;
            strb_q  <= pk_strb;
            if (overflow) begin
              // The word has no slot: never put it on the bus.
              error <= 1'b1;
              done  <= 1'b1;
              st    <= ST_FINISH;
            end else begin
              mem_valid <= 1'b1;
              mem_addr  <= word_addr(ADDR_BASE, word_count);
              mem_wdata <= pk_word;
              mem_wstrb <= pk_strb;
              tmo_cnt   <= '0;
              st        <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          if (mem_valid && mem_ready) begin
            mem_valid <= 1'b0;
            tmo_cnt   <= '0;
            if (VERIFY) begin
              mem_wstrb <= WSTRB_NONE;
              st        <= ST_READ;
            end else begin
              word_count <= wc_next;
              if (last_q) begin
                done <= 1'b1;
                st   <= ST_FINISH;
              end else begin
                s_ready <= 1'b1;
                st      <= ST_COLLECT;
              end
            end
          end else if (tmo_hit) begin
            mem_valid <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            st        <= ST_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ST_READ: begin
          if (!mem_valid) begin
            // One idle cycle after the write, then issue the read.
            mem_valid <= 1'b1;
            tmo_cnt   <= '0;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            tmo_cnt   <= '0;
            if (mismatch) begin
              error <= 1'b1;
              done  <= 1'b1;
              st    <= ST_FINISH;
            end else begin
              word_count <= wc_next;
              if (last_q) begin
                done <= 1'b1;
                st   <= ST_FINISH;
              end else begin
                s_ready <= 1'b1;
                st      <= ST_COLLECT;
              end
            end
          end else if (tmo_hit) begin
            mem_valid <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            st        <= ST_FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ST_FINISH: begin
          // Terminal; core release follows done by one cycle.
          s_ready     <= 1'b0;
          mem_valid   <= 1'b0;
          done        <= 1'b1;
          core_resetn <= ~error;
        end

        default: st <= ST_FINISH;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: two instances (verify/full-size and write-only/two-word),
// a memory responder, a word-level model of expected bus transfers and a
// per-cycle compare process.
module tb_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel;          // 0: instance a, 1: instance b
  logic        s_valid, s_last;
  logic [7:0]  s_data;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        a_s_ready, a_mem_valid, a_mem_instr, a_done, a_error, a_core_resetn;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic [15:0] a_word_count;
  logic [1:0]  a_fsm_state;
  logic        b_s_ready, b_mem_valid, b_mem_instr, b_done, b_error, b_core_resetn;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;
  logic [15:0] b_word_count;
  logic [1:0]  b_fsm_state;

  mem_loader #(.MEM_WORDS(256), .ADDR_BASE(32'h0), .VERIFY(1'b1), .TIMEOUT(64)) u_dut_a (
    .clk(clk), .reset(reset), .s_valid(s_valid & ~sel), .s_ready(a_s_ready), .s_data(s_data),
    .s_last(s_last), .mem_valid(a_mem_valid), .mem_instr(a_mem_instr), .mem_ready(mem_ready & ~sel),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(mem_rdata),
    .done(a_done), .error(a_error), .word_count(a_word_count), .core_resetn(a_core_resetn),
    .fsm_state(a_fsm_state)
  );

  mem_loader #(.MEM_WORDS(2), .ADDR_BASE(32'h0), .VERIFY(1'b0), .TIMEOUT(64)) u_dut_b (
    .clk(clk), .reset(reset), .s_valid(s_valid & sel), .s_ready(b_s_ready), .s_data(s_data),
    .s_last(s_last), .mem_valid(b_mem_valid), .mem_instr(b_mem_instr), .mem_ready(mem_ready & sel),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(mem_rdata),
    .done(b_done), .error(b_error), .word_count(b_word_count), .core_resetn(b_core_resetn),
    .fsm_state(b_fsm_state)
  );

  logic        s_ready, mem_valid, mem_instr, done, error, core_resetn;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [15:0] word_count;
  logic [1:0]  fsm_state;
  assign s_ready     = sel ? b_s_ready     : a_s_ready;
  assign mem_valid   = sel ? b_mem_valid   : a_mem_valid;
  assign mem_instr   = sel ? b_mem_instr   : a_mem_instr;
  assign mem_addr    = sel ? b_mem_addr    : a_mem_addr;
  assign mem_wdata   = sel ? b_mem_wdata   : a_mem_wdata;
  assign mem_wstrb   = sel ? b_mem_wstrb   : a_mem_wstrb;
  assign done        = sel ? b_done        : a_done;
  assign error       = sel ? b_error       : a_error;
  assign word_count  = sel ? b_word_count  : a_word_count;
  assign core_resetn = sel ? b_core_resetn : a_core_resetn;
  assign fsm_state   = sel ? b_fsm_state   : a_fsm_state;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- model: expected transfers {addr, data, strb} ----------------
  logic [67:0] exp_q[$];
  logic [7:0]  img[$];
  int          exp_wc;
  logic        exp_err;

  task automatic push_bytes(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) img.push_back(bytes[8*i +: 8]);
  endtask

  task automatic model_build(input bit verify, input int mem_words, input bit corrupt4);
    int nwords;
    logic [31:0] d;
    logic [31:0] a;
    logic [3:0]  s;
    nwords = (img.size() + 3) / 4;
    exp_wc = 0;
    exp_err = 1'b0;
    exp_q.delete();
    for (int w = 0; w < nwords; w++) begin
      if (w >= mem_words) begin
        exp_err = 1'b1;
        break;
      end
      d = 32'd0;
      s = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (4*w + k < img.size()) begin
          d[8*k +: 8] = img[4*w + k];
          s[k] = 1'b1;
        end
      end
      a = 32'(4*w);
      exp_q.push_back({a, d, s});
      if (verify) begin
        exp_q.push_back({a, 32'd0, 4'd0});
        if (corrupt4 && a == 32'h4) begin
          exp_err = 1'b1;
          break;
        end
      end
      exp_wc++;
    end
  endtask

  // ---------------- responder: ready one cycle after valid ----------------
  logic        resp_en, corrupt;
  logic [31:0] mem_arr [0:255];
  int          wait_cnt;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (mem_valid && resp_en) begin
        if (wait_cnt >= 1) begin
          mem_ready = 1'b1;
          if (mem_wstrb != 4'd0) begin
            for (int k = 0; k < 4; k++)
              if (mem_wstrb[k]) mem_arr[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
          end else begin
            mem_rdata = mem_arr[mem_addr[9:2]] ^ ((corrupt && mem_addr == 32'h4) ? 32'h1 : 32'h0);
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic        chk_en;
  logic        prev_valid;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;
  logic [67:0] e;

  always @(negedge clk) begin
    if (reset || !chk_en) begin
      prev_valid = 1'b0;
    end else if (mem_valid) begin
      check("s_ready_while_busy", s_ready, 1'b0);
      check("mem_instr", mem_instr, 1'b0);
      if (prev_valid) begin
        check("addr_stable", mem_addr, prev_addr);
        check("wdata_stable", mem_wdata, prev_wdata);
        check("wstrb_stable", mem_wstrb, prev_wstrb);
      end
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_txn: addr %h wstrb %h, required no transfer", mem_addr, mem_wstrb);
        end else begin
          e = exp_q.pop_front();
          check("txn_addr", mem_addr, e[67:36]);
          check("txn_wstrb", mem_wstrb, e[3:0]);
          if (e[3:0] != 4'd0) check("txn_wdata", mem_wdata, e[35:4]);
        end
        prev_valid = 1'b0;
      end else begin
        prev_valid = 1'b1;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wstrb = mem_wstrb;
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL byte_accept: s_ready 0 after %0d cycles, required 1", n);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic stream();
    for (int i = 0; i < img.size(); i++) send_byte(img[i], i == img.size() - 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    img.delete();
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_final(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_word_count"}, word_count, 32'(exp_wc));
    check({tag, "_core_resetn"}, core_resetn, !exp_err);
    check({tag, "_pending_txns"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_mem_valid"}, mem_valid, 1'b0);
  endtask

  // ---------------- directed tests ----------------
  logic [67:0] pin;
  int cnt;
  int n;

  initial begin
    reset = 1'b1; sel = 1'b0; resp_en = 1'b1; corrupt = 1'b0; chk_en = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_word_count", word_count, 16'd0);
    check("rst_core_resetn", core_resetn, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1'b1);

    // two full words with read-back
    img.delete();
    push_bytes(64'h3FC0_0093_0010_0013, 8);
    model_build(1'b1, 256, 1'b0);
    pin = exp_q[0];
    check("model_w0_data", pin[35:4], 32'h0010_0013);
    pin = exp_q[2];
    check("model_w1_addr", pin[67:36], 32'h4);
    check("model_w1_data", pin[35:4], 32'h3FC0_0093);
    stream();
    check_final("full");

    // partial final word
    do_reset();
    push_bytes(64'h0000_FFEE_DDCC_BBAA, 6);
    model_build(1'b1, 256, 1'b0);
    pin = exp_q[2];
    check("model_part_data", pin[35:4], 32'h0000_FFEE);
    check("model_part_strb", pin[3:0], 4'b0011);
    stream();
    check_final("partial");

    // read-back corruption on word 1
    do_reset();
    corrupt = 1'b1;
    push_bytes(64'h3FC0_0093_0010_0013, 8);
    model_build(1'b1, 256, 1'b1);
    check("model_corrupt_wc", 32'(exp_wc), 32'd1);
    stream();
    check_final("verify_err");
    corrupt = 1'b0;

    // overflow on the two-word write-only instance
    sel = 1'b1;
    do_reset();
    push_bytes(64'h0706_0504_0302_0100, 8);
    push_bytes(64'h0B0A_0908, 4);
    model_build(1'b0, 2, 1'b0);
    check("model_ovf_txns", 32'(exp_q.size()), 32'd2);
    stream();
    check_final("overflow");
    s_valid = 1'b1;
    s_data  = 8'h5A;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ready || mem_valid) cnt++;
    end
    s_valid = 1'b0;
    check("ovf_idle_after", 32'(cnt), 32'd0);
    sel = 1'b0;

    // timeout: responder never answers
    do_reset();
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
    n = 0;
    while (!mem_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    while (mem_valid && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_valid_cycles", 32'(cnt), 32'd64);
    exp_err = 1'b1;
    exp_wc = 0;
    check_final("timeout");

    // async reset mid-write, then a clean load from the base address
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'(i + 16), 1'b0);
    n = 0;
    while (!mem_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_write_valid_seen", mem_valid, 1'b1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mem_valid", mem_valid, 1'b0);
    check("async_rst_word_count", word_count, 16'd0);
    check("async_rst_mem_addr", mem_addr, 32'h0);
    resp_en = 1'b1;
    do_reset();
    push_bytes(64'h3FC0_0093_0010_0013, 8);
    model_build(1'b1, 256, 1'b0);
    stream();
    check_final("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Bus initiator on the native picorv32 memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Accepts a byte stream over a valid/ready port, packs bytes little-endian into 32-bit words and writes them to consecutive word addresses in program memory. Optionally reads each word back and compares it.
- Holds the core in reset (core_resetn low) until loading completes cleanly. Sits between a host/UART byte source and the memory responder, ahead of the core's arbiter.

Parameters:
- MEM_WORDS, 256, number of writable words; words beyond this are an overflow error.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- VERIFY, 1, 1 = read-back and compare after every write; 0 = write only.
- TIMEOUT, 64, maximum cycles mem_valid may wait for mem_ready before a timeout error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  byte-stream valid
- s_ready  out  1  byte-stream ready
- s_data  in  8  byte-stream data
- s_last  in  1  marks the final byte of the image
- mem_valid  out  1  transaction request
- mem_instr  out  1  tied 0
- mem_ready  in  1  responder completion
- mem_addr  out  32  byte address, word aligned
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 = read
- mem_rdata  in  32  read data, valid when mem_ready=1
- done  out  1  load finished (sticky until reset)
- error  out  1  overflow, timeout or verify mismatch (sticky)
- word_count  out  16  words written so far
- core_resetn  out  1  core reset release; 1 only when done=1 and error=0

Behaviour:
- Reset (async, applies immediately, including mid-transaction): state COLLECT, mem_valid=0, mem_wstrb=0, mem_addr=ADDR_BASE, mem_wdata=0, s_ready=0, done=0, error=0, word_count=0, core_resetn=0, byte index=0. s_ready=1 from the first clock edge after reset deasserts.
- States: COLLECT, WRITE, READ, FINISH.
- COLLECT:
  - s_ready=1. Each s_valid&s_ready cycle places s_data in lane byte_idx (lane 0 = [7:0]), sets strobe bit byte_idx and increments byte_idx mod 4.
  - Go to WRITE on acceptance of the 4th byte, or on s_last with at least 1 byte in the current word.
  - Partial last word: wstrb has only the received lanes set; unused lanes of wdata are 0.
- WRITE:
  - s_ready=0; mem_valid=1 starting the cycle after the triggering byte.
  - mem_addr = ADDR_BASE + 4*word_count. mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid=1.
  - The transfer completes on the cycle mem_valid&mem_ready; mem_valid drops on the next cycle.
  - On completion: go to READ if VERIFY=1. Otherwise increment word_count and go to FINISH if the word carried s_last, else COLLECT.
- READ:
  - mem_valid=1, mem_wstrb=0, same address. On mem_ready, compare mem_rdata with wdata under the strobe mask.
  - Mismatch: error=1, go to FINISH.
  - Match: increment word_count, then FINISH if last, else COLLECT.
- s_last with byte_idx=0 (empty word): go directly to FINISH.
- Overflow: a word whose index is ≥ MEM_WORDS is never issued on the bus. error=1 and go to FINISH; all further bytes are ignored (s_ready=0).
- Timeout: a counter runs while mem_valid=1 and clears on completion. Reaching TIMEOUT cycles sets error=1, deasserts mem_valid and goes to FINISH.
- FINISH: terminal until reset. done=1, s_ready=0, mem_valid=0. core_resetn=1 only if error=0, registered one cycle after done rises.
- mem_ready while mem_valid=0 is ignored. Back-pressure from a slow responder stalls the byte stream (s_ready=0 outside COLLECT).
- word_count saturates at 16'hFFFF.

Decomposition:
- Shared package (mem_bus_pkg): state encoding localparams, WSTRB_NONE/WSTRB_ALL constants, word-address helper function.
- One natural sub-module: byte_packer. It holds byte_idx, data, strobes and a "word complete" flag, and is reused by the future UART loader.
- Bus FSM and timeout counter stay in the top module.

Test Plan:
- Stream 8 bytes 13,00,10,00,93,00,C0,3F (s_last on the 8th) to a zero-wait responder that asserts ready 1 cycle after valid → writes 32'h00100013 @0x0 then 32'h3FC00093 @0x4 with wstrb=4'hF; done=1, word_count=2, core_resetn=1.
- 6 bytes AA,BB,CC,DD,EE,FF with s_last on FF → second write 32'h0000FFEE @0x4 with wstrb=4'b0011; read-back passes; error=0.
- VERIFY=1 with a responder that corrupts bit 0 on reads of 0x4 → error=1, done=1, core_resetn stays 0, word_count=1.
- MEM_WORDS=2, stream 12 bytes → exactly 2 writes issued, no bus activity for word 2, error=1, s_ready=0 thereafter.
- Responder never asserts ready, TIMEOUT=64 → mem_valid high for exactly 64 cycles then drops; error=1.
- Assert reset while mem_valid=1 mid-write → mem_valid=0 immediately (async). Next stream restarts at ADDR_BASE with word_count=0.
